// File: rtl/minute_dmem.sv
// minute_dmem: byte-addressable data memory for the minuteCore memory stage.
//
// One load/store request is served per cycle. Read data and the ready pulse
// are registered, so a request presented in one cycle completes in the next.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high; clears r_data and ready (not the array)
//   addr      byte address; only the low log2(DEPTH_BYTES) bits are used
//   r_enable  read request: full little-endian word starting at addr
//   w_enable  write request, size chosen by w_size
//   w_size    00 byte, 01 halfword, 10/11 word
//   w_data    write data, taken from the low-order bytes
//   r_data    registered read data, held until the next accepted read
//   ready     one-cycle pulse: the previous cycle's request has completed
//   finish    core halt; while high all requests are ignored
//
// Optional build macro DMEM_DUMP_EN: on the first clock edge of each finish
// assertion, the full array is displayed as a hex image of little-endian
// words, followed by a "DMEM DUMP <n>" message. Simulation-only; leave it
// undefined for synthesis.

module minute_dmem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_BYTES = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  r_enable,
  input  logic                  w_enable,
  input  logic [1:0]            w_size,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  ready,
  input  logic                  finish
);

  localparam int IW = $clog2(DEPTH_BYTES);

  logic [7:0] mem [DEPTH_BYTES];

  // reset is also folded in here so the (unreset) array is never written
  // while the rest of the block is being held in reset.
  logic accept;
  assign accept = (r_enable | w_enable) & ~finish & ~reset;

  logic [IW-1:0]         lane_idx   [4];
  logic [7:0]            lane_wbyte [4];
  logic [7:0]            lane_rbyte [4];
  logic [3:0]            lane_wen;
  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    lane_wen    = 4'b0000;
    lane_wen[0] = accept & w_enable;
    lane_wen[1] = accept & w_enable & (w_size != 2'b00);
    lane_wen[2] = accept & w_enable & w_size[1];
    lane_wen[3] = accept & w_enable & w_size[1];
  end

  // Each byte lane addresses its own array entry; the IW-bit add makes
  // multi-byte accesses wrap at the top of memory. A lane being written
  // forwards its new byte into the read path, giving write-first semantics
  // for a simultaneous read and write.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_idx[gi]   = addr[IW-1:0] + IW'(gi);
      assign lane_wbyte[gi] = w_data[8*gi +: 8];
      assign lane_rbyte[gi] = lane_wen[gi] ? lane_wbyte[gi] : mem[lane_idx[gi]];
    end
  endgenerate

  assign rd_word = {lane_rbyte[3], lane_rbyte[2], lane_rbyte[1], lane_rbyte[0]};

  // Upper address bits simply alias the memory.
  generate
    if (ADDR_WIDTH > IW) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[ADDR_WIDTH-1:IW];
    end
  endgenerate

  // Array contents survive reset, so the write port has no reset branch.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_wen[i]) begin
        mem[lane_idx[i]] <= lane_wbyte[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
      ready  <= 1'b0;
    end else begin
      ready <= accept;
      if (accept && r_enable) begin
        r_data <= rd_word;
      end
    end
  end

`ifdef DMEM_DUMP_EN
  // Edge detect on finish so the image is emitted once per assertion.
  logic finish_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      finish_q <= 1'b0;
    end else begin
      finish_q <= finish;
    end
  end

  always @(posedge clk) begin : p_dump
    if (finish && !finish_q && !reset) begin
      for (int w = 0; w < DEPTH_BYTES / 4; w++) begin
        $display("%02h%02h%02h%02h",
                 mem[4*w+3], mem[4*w+2], mem[4*w+1], mem[4*w]);
      end
      $display("DMEM DUMP %0d", DEPTH_BYTES / 4);
    end
  end
`endif

endmodule

// File: tb/tb_minute_dmem.sv
module tb_minute_dmem;

  localparam int DEPTH = 4096;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        r_enable;
  logic        w_enable;
  logic [1:0]  w_size;
  logic [31:0] w_data;
  logic [31:0] r_data;
  logic        ready;
  logic        finish;

  minute_dmem #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH_BYTES(DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .r_enable(r_enable),
    .w_enable(w_enable),
    .w_size  (w_size),
    .w_data  (w_data),
    .r_data  (r_data),
    .ready   (ready),
    .finish  (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Monitor: every ready pulse must match the oldest outstanding request,
  // arrive exactly on its due cycle, and show the expected r_data.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL spurious_ready cyc=%0d r_data=%08h required no ready", cyc, r_data);
        end else begin
          e = exp_q.pop_front();
          if (e.due != cyc || r_data !== e.exp) begin
            failures++;
            $display("FAIL %s cyc=%0d due=%0d r_data=%08h required=%08h",
                     e.name, cyc, e.due, r_data, e.exp);
          end else begin
            $display("ok   %s cyc=%0d r_data=%08h", e.name, cyc, r_data);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL %s missing_ready cyc=%0d due=%0d ready=0 required=1", e.name, cyc, e.due);
      end
    end
  end

  // Drive one request for one cycle; exp is the r_data expected when it completes.
  task automatic issue(input string name, input bit r, input bit w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
    exp_t e;
    r_enable = r;
    w_enable = w;
    w_size   = sz;
    addr     = a;
    w_data   = d;
    if (!finish) begin
      e.due  = cyc + 1;
      e.exp  = exp;
      e.name = name;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    r_enable = 1'b0;
    w_enable = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_now(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end else begin
      $display("ok   %s value=%08h", name, act);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    r_enable = 1'b1;
    w_enable = 1'b0;
    w_size   = 2'b10;
    addr     = 32'h10;
    w_data   = 32'h0;
    finish   = 1'b0;

    // Reset held with a read requested: outputs stay cleared.
    repeat (2) begin
      @(negedge clk);
      check_now("reset_r_data", r_data, 32'h0);
      check_now("reset_ready", {31'b0, ready}, 32'h0);
    end
    @(posedge clk); #1;
    reset    = 1'b0;
    r_enable = 1'b0;
    idle(2);
    @(negedge clk);
    check_now("idle_ready", {31'b0, ready}, 32'h0);
    @(posedge clk); #1;

    // Word round-trip (0x14 cleared so the unaligned read is defined).
    issue("wr_14_zero",  0, 1, 2'b10, 32'h14, 32'h0000_0000, 32'h0);
    issue("wr_10_word",  0, 1, 2'b10, 32'h10, 32'hDEAD_BEEF, 32'h0);
    idle(1);
    issue("rd_10",       1, 0, 2'b00, 32'h10, 32'h0,         32'hDEAD_BEEF);
    issue("rd_11_unal",  1, 0, 2'b00, 32'h11, 32'h0,         32'h00DE_ADBE);
    idle(1);

    // Sub-word writes; upper w_data bits must be ignored.
    issue("wr_20_word",  0, 1, 2'b10, 32'h20, 32'h1122_3344, 32'h00DE_ADBE);
    issue("wr_21_byte",  0, 1, 2'b00, 32'h21, 32'hFFFF_FFAA, 32'h00DE_ADBE);
    issue("wr_22_half",  0, 1, 2'b01, 32'h22, 32'hFFFF_BBCC, 32'h00DE_ADBE);
    issue("rd_20",       1, 0, 2'b00, 32'h20, 32'h0,         32'hBBCC_AA44);
    idle(1);

    // Same-cycle write+read (write-first), then a back-to-back read.
    issue("rw_40",       1, 1, 2'b10, 32'h40, 32'h1234_5678, 32'h1234_5678);
    issue("rd_10_b2b",   1, 0, 2'b00, 32'h10, 32'h0,         32'hDEAD_BEEF);
    idle(1);

    // w_size=11 behaves as a word write.
    issue("wr_50_sz11",  0, 1, 2'b11, 32'h50, 32'hA5A5_A5A5, 32'hDEAD_BEEF);
    issue("rd_50",       1, 0, 2'b00, 32'h50, 32'h0,         32'hA5A5_A5A5);
    idle(2);
    @(negedge clk);
    check_now("hold_r_data", r_data, 32'hA5A5_A5A5);
    @(posedge clk); #1;

    // Wrap-around at the top of memory.
    issue("wr_0_zero",   0, 1, 2'b10, 32'h0,       32'h0,         32'hA5A5_A5A5);
    issue("wr_top_zero", 0, 1, 2'b10, DEPTH - 4,   32'h0,         32'hA5A5_A5A5);
    issue("wr_wrap",     0, 1, 2'b10, DEPTH - 2,   32'hCAFE_F00D, 32'hA5A5_A5A5);
    issue("rd_wrap",     1, 0, 2'b00, DEPTH - 2,   32'h0,         32'hCAFE_F00D);
    issue("rd_top",      1, 0, 2'b00, DEPTH - 4,   32'h0,         32'hF00D_0000);
    issue("rd_0",        1, 0, 2'b00, 32'h0,       32'h0,         32'h0000_CAFE);
    issue("rd_alias",    1, 0, 2'b00, DEPTH + 16,  32'h0,         32'hDEAD_BEEF);
    idle(2);

    // Finish: requests ignored, outputs and contents frozen.
    finish = 1'b1;
    issue("fin_wr",      0, 1, 2'b10, 32'h10, 32'hFFFF_FFFF, 32'h0);
    issue("fin_rd",      1, 0, 2'b00, 32'h40, 32'h0,         32'h0);
    @(negedge clk);
    check_now("fin_ready", {31'b0, ready}, 32'h0);
    check_now("fin_r_data", r_data, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    idle(1);
    finish = 1'b0;
    issue("rd_10_after", 1, 0, 2'b00, 32'h10, 32'h0,         32'hDEAD_BEEF);
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain outstanding=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
